udp_panel_reader: RTL and testbench
===================================

# udp_panel_reader

Readback counterpart of the UDP panel write path. On a start request it reads a run of consecutive words from one panel's memory over the ctrl read port and streams them as a single UDP payload into the UDP core's sink. Each word goes out as a 4-byte record: address high, address low, data high, data low. This is the same record format the host uses for writes, so the host can diff written and read-back frames directly.

## Interface
Parameters:
- NUM_PANELS, 9: number of panel memories; width of ctrl_rd_en.
- RD_LATENCY, 1: cycles from ctrl_rd_en asserted to ctrl_rdat valid; legal range 1..7.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- start_addr  in  16  first panel word address.
- word_count  in  16  number of words to send; 0 is rejected.
- panel_sel  in  4  panel index, 0..NUM_PANELS-1.
- busy  out  1  high from accepted start until the last byte is accepted.
- done  out  1  one-cycle pulse on the cycle after the last byte handshake.
- error  out  1  one-cycle pulse when a start is rejected.
- ctrl_rd_en  out  NUM_PANELS  one-hot read strobe, one cycle per word.
- ctrl_addr  out  16  read address; held stable while a read is outstanding.
- ctrl_rdat  in  24  read data; bits [15:0] are used, [23:16] are ignored.
- udp1_sink_valid  out  1  byte available.
- udp1_sink_last  out  1  marks the final byte of the packet; qualified by valid.
- udp1_sink_ready  in  1  the UDP core accepts the byte.
- udp1_sink_data  out  8  payload byte.

## Operation
- States: IDLE, HDR (only if compiled in), READ, WAIT, SEND.
- IDLE:
  - A start with word_count≠0 and panel_sel<NUM_PANELS latches addr, remaining count and panel, and sets busy.
  - The next state is HDR if the header is compiled in, otherwise READ.
  - Any other start pulses error for one cycle and stays in IDLE.
- READ:
  - Assert ctrl_rd_en[panel] for exactly one cycle with ctrl_addr=addr.
  - Go to WAIT.
- WAIT:
  - Count RD_LATENCY cycles from the READ cycle.
  - On the RD_LATENCY-th cycle, capture {addr, ctrl_rdat[15:0]} into a 32-bit holding register and go to SEND.
- SEND:
  - Present bytes [31:24], [23:16], [15:8], [7:0] in that order.
  - Advance one byte per cycle in which valid&&ready.
  - After byte 3 is accepted: decrement remaining count and increment addr (wrapping 16'hFFFF→16'h0000).
  - If remaining count is nonzero, go to READ; otherwise go to IDLE, clear busy and pulse done.
- udp1_sink_last=1 only on byte 3 of the final word.
- Start pulses while busy are ignored: no error, no effect.
- The block never drops or reorders bytes. Back-pressure stalls SEND indefinitely and issues no extra reads.

## Timing
- Reset values: state IDLE; all outputs 0, including ctrl_addr and udp1_sink_data.
- Start to first ctrl_rd_en: 1 cycle without header.
- ctrl_rd_en to first udp1_sink_valid: RD_LATENCY+1 cycles.
- Per-word cost with ready held high: 1 (READ) + RD_LATENCY (WAIT) + 4 (SEND) cycles.
- Stream handshake:
  - valid, data and last stay stable while valid&&!ready.
  - valid does not depend combinationally on ready.
  - valid is driven low in IDLE, READ and WAIT.
- Reset asserted mid-packet: outputs clear immediately. The truncated packet is not completed; the UDP core handles it as a dropped frame.
- done and error are registered and never assert in the same cycle.

## Configuration
- UDP_READER_HEADER_EN defined:
  - HDR state emits 2 bytes before the first record: word_count[15:8] then word_count[7:0], with the same handshake.
  - From HDR the block goes to READ after the second header byte is accepted.
  - Start to first ctrl_rd_en becomes ≥3 cycles.
- UDP_READER_HEADER_EN undefined: there is no HDR state, and the packet is exactly 4×word_count bytes.

## Test plan
- Single word, ready=1, RD_LATENCY=1: start_addr=16'h0010, panel_sel=2, word_count=1, memory[0x10]=16'hBEEF.
  - Expect ctrl_rd_en=9'b000000100 for one cycle.
  - Expect bytes 00,10,BE,EF with last only on EF, then a done pulse and busy low.
- Back-pressure: word_count=3, ready toggling 1,0,0,1 repeating.
  - Expect 12 bytes in order, valid/data/last stable during stalls, and exactly 3 read strobes.
- Address wrap: start_addr=16'hFFFF, word_count=2.
  - Expect records addressed FF FF and 00 00, reading addresses 0xFFFF then 0x0000.
- Rejects: word_count=0 → one error pulse, busy stays 0. panel_sel=9 → one error pulse, no ctrl_rd_en.
  - A start while busy → no error and no change to the stream.
- Reset mid-stream: deassert reset_n during byte 2 of word 1 of a 4-word run.
  - Expect valid, busy and ctrl_rd_en 0 immediately.
  - After release, a new start=1-word run completes normally.
- With UDP_READER_HEADER_EN: word_count=16'h0102 → first two bytes 01,02, then records, for 4×258+2=1034 bytes total.

Source files
------------

// File: rtl/udp_panel_reader.sv
// Reads a run of consecutive panel words over the ctrl read port and streams them as 4-byte
// {addr, data} records into the UDP sink. Define UDP_READER_HEADER_EN to prefix a 2-byte word count.
module udp_panel_reader #(
   parameter int NUM_PANELS = 9,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [15:0]           start_addr,
   input  logic [15:0]           word_count,
   input  logic [3:0]            panel_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [NUM_PANELS-1:0] ctrl_rd_en,
   output logic [15:0]           ctrl_addr,
   input  logic [23:0]           ctrl_rdat,
   output logic                  udp1_sink_valid,
   output logic                  udp1_sink_last,
   input  logic                  udp1_sink_ready,
   output logic [7:0]            udp1_sink_data
);
   localparam logic [4:0]            LP_NUM_PANELS = 5'(NUM_PANELS);
   localparam logic [2:0]            LP_RD_LAT     = 3'(RD_LATENCY);
   localparam logic [NUM_PANELS-1:0] LP_ONE        = {{(NUM_PANELS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef UDP_READER_HEADER_EN
      S_HDR,
`endif
      S_READ,
      S_WAIT,
      S_SEND
   } state_t;

`ifdef UDP_READER_HEADER_EN
   localparam state_t LP_FIRST = S_HDR;
`else
   localparam state_t LP_FIRST = S_READ;
`endif

   state_t      r_state, w_next;
   logic [15:0] r_addr, r_remain;
   logic [3:0]  r_panel;
   logic [2:0]  r_lat_cnt;
   logic [1:0]  r_byte;
   logic [31:0] r_hold;
   logic        r_busy, r_done, r_error;
   logic        w_accept, w_valid, w_fire, w_final, w_unused;

   assign w_accept = ({1'b0, panel_sel} < LP_NUM_PANELS) && (word_count != 16'd0);
   assign w_final  = (r_remain == 16'd1);
   assign w_unused = ^ctrl_rdat[23:16];
`ifdef UDP_READER_HEADER_EN
   assign w_valid  = (r_state == S_SEND) || (r_state == S_HDR);
`else
   assign w_valid  = (r_state == S_SEND);
`endif
   // valid comes only from state, so it never depends on ready
   assign w_fire          = w_valid && udp1_sink_ready;
   assign udp1_sink_valid = w_valid;
   assign ctrl_addr       = r_addr;
   assign busy            = r_busy;
   assign done            = r_done;
   assign error           = r_error;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      ctrl_rd_en     = '0;
      udp1_sink_last = 1'b0;
      udp1_sink_data = 8'h00;
      case (r_state)
         S_IDLE: if (start && w_accept) w_next = LP_FIRST;
`ifdef UDP_READER_HEADER_EN
         S_HDR: begin
            udp1_sink_data = (r_byte == 2'd0) ? r_remain[15:8] : r_remain[7:0];
            if (w_fire && r_byte == 2'd1) w_next = S_READ;
         end
`endif
         S_READ: begin
            ctrl_rd_en = LP_ONE << r_panel;
            w_next     = S_WAIT;
         end
         S_WAIT: if (r_lat_cnt == LP_RD_LAT) w_next = S_SEND;
         S_SEND: begin
            case (r_byte)
               2'd0:    udp1_sink_data = r_hold[31:24];
               2'd1:    udp1_sink_data = r_hold[23:16];
               2'd2:    udp1_sink_data = r_hold[15:8];
               default: udp1_sink_data = r_hold[7:0];
            endcase
            udp1_sink_last = (r_byte == 2'd3) && w_final;
            if (w_fire && r_byte == 2'd3) w_next = w_final ? S_IDLE : S_READ;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr    <= 16'd0;
         r_remain  <= 16'd0;
         r_panel   <= 4'd0;
         r_lat_cnt <= 3'd0;
         r_byte    <= 2'd0;
         r_hold    <= 32'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               if (w_accept) begin
                  r_addr   <= start_addr;
                  r_remain <= word_count;
                  r_panel  <= panel_sel;
                  r_byte   <= 2'd0;
                  r_busy   <= 1'b1;
               end else begin
                  r_error  <= 1'b1;
               end
            end
`ifdef UDP_READER_HEADER_EN
            S_HDR: if (w_fire) r_byte <= (r_byte == 2'd1) ? 2'd0 : r_byte + 2'd1;
`endif
            S_READ: r_lat_cnt <= 3'd1;
            S_WAIT: begin
               if (r_lat_cnt == LP_RD_LAT) r_hold    <= {r_addr, ctrl_rdat[15:0]};
               else                        r_lat_cnt <= r_lat_cnt + 3'd1;
            end
            S_SEND: if (w_fire) begin
               // byte index wraps 3->0, ready for the next record
               r_byte <= r_byte + 2'd1;
               if (r_byte == 2'd3) begin
                  r_remain <= r_remain - 16'd1;
                  r_addr   <= r_addr + 16'd1;
                  if (w_final) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_udp_panel_reader.sv
// Randomized self-checking bench for udp_panel_reader against a record-level reference model.
`timescale 1ns/1ps
module tb_udp_panel_reader;
   localparam int NP  = 9;
   localparam int LAT = 1;
`ifdef UDP_READER_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif

   logic          clock = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [15:0]   start_addr = 16'd0, word_count = 16'd0;
   logic [3:0]    panel_sel = 4'd0;
   logic          busy, done, error;
   logic [NP-1:0] ctrl_rd_en;
   logic [15:0]   ctrl_addr;
   logic [23:0]   ctrl_rdat;
   logic          udp1_sink_valid, udp1_sink_last, udp1_sink_ready = 1'b1;
   logic [7:0]    udp1_sink_data;
   int            checks = 0, errors = 0;

   always #5 clock = ~clock;

   udp_panel_reader #(.NUM_PANELS(NP), .RD_LATENCY(LAT)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
      .word_count(word_count), .panel_sel(panel_sel), .busy(busy), .done(done), .error(error),
      .ctrl_rd_en(ctrl_rd_en), .ctrl_addr(ctrl_addr), .ctrl_rdat(ctrl_rdat),
      .udp1_sink_valid(udp1_sink_valid), .udp1_sink_last(udp1_sink_last),
      .udp1_sink_ready(udp1_sink_ready), .udp1_sink_data(udp1_sink_data));

   // Panel memory: data valid exactly LAT cycles after the strobe, junk otherwise
   logic [15:0] mem [0:65535];
   logic [16:0] pipe [LAT];
   logic [23:0] junk;
   always @(posedge clock) begin
      junk    <= $urandom;
      pipe[0] <= {|ctrl_rd_en, mem[ctrl_addr]};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ctrl_rdat = pipe[LAT-1][16] ? {junk[23:16], pipe[LAT-1][15:0]} : junk;

   int rmode = 0, rph = 0;
   always @(posedge clock) begin
      #1;
      case (rmode)
         1:       begin udp1_sink_ready = (rph == 0) || (rph == 3); rph = (rph + 1) % 4; end
         2:       udp1_sink_ready = 1'($urandom_range(0, 1));
         default: udp1_sink_ready = 1'b1;
      endcase
   end

   int cyc = 0, s_cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [8:0]    byte_q[$];
   logic [15:0]   rda_q[$];
   logic [NP-1:0] rde_q[$];
   int            rdc_q[$];
   int            done_cnt = 0, err_cnt = 0, proto_viol = 0, t_v1 = -1;
   logic          pstall = 1'b0;
   logic [8:0]    pbyte = 9'd0;
   always @(negedge clock) begin
      if (!reset_n) pstall = 1'b0;
      else begin
         if (pstall && !(udp1_sink_valid && {udp1_sink_last, udp1_sink_data} === pbyte)) proto_viol++;
         if (udp1_sink_valid && |ctrl_rd_en) proto_viol++;
         if (done && error) proto_viol++;
         if (|ctrl_rd_en) begin
            rda_q.push_back(ctrl_addr); rde_q.push_back(ctrl_rd_en); rdc_q.push_back(cyc);
         end
         if (udp1_sink_valid && t_v1 < 0 && rdc_q.size() > 0) t_v1 = cyc;
         if (udp1_sink_valid && udp1_sink_ready) byte_q.push_back({udp1_sink_last, udp1_sink_data});
         pstall = udp1_sink_valid && !udp1_sink_ready;
         pbyte  = {udp1_sink_last, udp1_sink_data};
         if (done)  done_cnt++;
         if (error) err_cnt++;
      end
   end

   // Reference model: the packet the host should receive for a run
   logic [8:0] exp_q[$];
   function automatic void build_exp(input logic [15:0] a, input int n);
      logic [15:0] ad, d;
      exp_q = {};
`ifdef UDP_READER_HEADER_EN
      exp_q.push_back({1'b0, 8'(n >> 8)});
      exp_q.push_back({1'b0, 8'(n)});
`endif
      for (int i = 0; i < n; i++) begin
         ad = a + 16'(i);
         d  = mem[ad];
         exp_q.push_back({1'b0, ad[15:8]});
         exp_q.push_back({1'b0, ad[7:0]});
         exp_q.push_back({1'b0, d[15:8]});
         exp_q.push_back({i == n - 1, d[7:0]});
      end
   endfunction

   function automatic int stream_diff();
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) return i;
      if (byte_q.size() != exp_q.size()) return exp_q.size();
      return -1;
   endfunction

   function automatic int rd_diff(input logic [15:0] a, input int n, input int p);
      if (rda_q.size() != n) return -2;
      for (int i = 0; i < n; i++)
         if (rda_q[i] !== a + 16'(i) || rde_q[i] !== (NP'(1) << p)) return i;
      return -1;
   endfunction

   task automatic clear_mon();
      byte_q = {}; rda_q = {}; rde_q = {}; rdc_q = {};
      done_cnt = 0; err_cnt = 0; proto_viol = 0; t_v1 = -1; rph = 0;
   endtask

   task automatic pulse_start(input logic [15:0] a, input logic [15:0] n, input logic [3:0] p);
      @(posedge clock); #2;
      start = 1'b1; start_addr = a; word_count = n; panel_sel = p; s_cyc = cyc;
      @(posedge clock); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int n0;
      n0 = done_cnt; to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clock); #1;
         if (done_cnt != n0) begin to = 1'b0; break; end
      end
   endtask

   task automatic run(input logic [15:0] a, input int n, input int p, input int rm, output bit to);
      clear_mon(); rmode = rm; build_exp(a, n);
      pulse_start(a, 16'(n), 4'(p));
      wait_done(n * (LAT + 5) * 8 + 50, to);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      checks++; if ({udp1_sink_valid, udp1_sink_last, udp1_sink_data, busy, done, error, ctrl_rd_en, ctrl_addr} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", {udp1_sink_valid, udp1_sink_last, udp1_sink_data, busy, done, error, ctrl_rd_en, ctrl_addr}); end
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      checks++; if ({udp1_sink_valid, busy, done, error, ctrl_rd_en} !== '0) begin
         errors++; $display("FAIL post_reset_idle got %h want 0", {udp1_sink_valid, busy, done, error, ctrl_rd_en}); end
   endtask

   task automatic test_single();
      bit to; logic [8:0] k [4];
      k = '{9'h000, 9'h010, 9'h0BE, 9'h1EF};
      mem[16'h0010] = 16'hBEEF;
      run(16'h0010, 1, 2, 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %0d want 0", to); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (byte_q.size() != 4 + HDR || byte_q[HDR+i] !== k[i]) begin
            errors++; $display("FAIL single_byte%0d got %h want %h", i, (byte_q.size() > HDR + i) ? byte_q[HDR+i] : 9'h1FF, k[i]); end
      end
      checks++; if (rde_q.size() != 1 || rde_q[0] !== 9'b000000100) begin
         errors++; $display("FAIL single_rd_en got %0d strobes first %b want 1 x 000000100", rde_q.size(), (rde_q.size() > 0) ? rde_q[0] : '0); end
      checks++; if (done_cnt !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_done got done=%0d busy=%b want 1/0", done_cnt, busy); end
`ifdef UDP_READER_HEADER_EN
      checks++; if (rdc_q.size() == 0 || rdc_q[0] - s_cyc < 3) begin
         errors++; $display("FAIL start_to_rd got %0d want >=3", (rdc_q.size() > 0) ? rdc_q[0] - s_cyc : -1); end
`else
      checks++; if (rdc_q.size() == 0 || rdc_q[0] - s_cyc !== 1) begin
         errors++; $display("FAIL start_to_rd got %0d want 1", (rdc_q.size() > 0) ? rdc_q[0] - s_cyc : -1); end
`endif
      checks++; if (rdc_q.size() == 0 || t_v1 - rdc_q[0] !== LAT + 1) begin
         errors++; $display("FAIL rd_to_valid got %0d want %0d", (rdc_q.size() > 0) ? t_v1 - rdc_q[0] : -1, LAT + 1); end
   endtask

   task automatic test_backpressure();
      bit to; logic [15:0] a; int p, sd, rd;
      a = 16'($urandom); p = $urandom_range(0, NP - 1);
      run(a, 3, p, 1, to);
      sd = stream_diff(); rd = rd_diff(a, 3, p);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %0d want 0", to); end
      checks++; if (sd !== -1) begin errors++; $display("FAIL bp_stream got first bad byte %0d want none", sd); end
      checks++; if (rd !== -1) begin errors++; $display("FAIL bp_reads got diff %0d (%0d strobes) want none (3)", rd, rda_q.size()); end
      checks++; if (proto_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d violations want 0", proto_viol); end
   endtask

   task automatic test_wrap();
      bit to; int sd, rd;
      run(16'hFFFF, 2, 5, 0, to);
      sd = stream_diff(); rd = rd_diff(16'hFFFF, 2, 5);
      checks++; if (to !== 1'b0 || sd !== -1) begin errors++; $display("FAIL wrap_stream got to=%0d diff=%0d want 0/-1", to, sd); end
      checks++; if (rd !== -1 || rda_q.size() != 2 || rda_q[1] !== 16'h0000) begin
         errors++; $display("FAIL wrap_reads got diff %0d want reads FFFF,0000", rd); end
   endtask

   task automatic test_reject();
      logic bseen;
      clear_mon(); bseen = 1'b0;
      pulse_start(16'h1234, 16'd0, 4'd3);
      repeat (4) begin @(posedge clock); #1; bseen |= busy; end
      checks++; if (err_cnt !== 1 || bseen !== 1'b0) begin
         errors++; $display("FAIL reject_zero got err=%0d busy=%b want 1/0", err_cnt, bseen); end
      clear_mon();
      pulse_start(16'h1234, 16'd5, 4'd9);
      repeat (4) begin @(posedge clock); #1; bseen |= busy; end
      checks++; if (err_cnt !== 1 || rda_q.size() != 0 || bseen !== 1'b0 || done_cnt !== 0) begin
         errors++; $display("FAIL reject_panel got err=%0d rds=%0d busy=%b done=%0d want 1/0/0/0", err_cnt, rda_q.size(), bseen, done_cnt); end
   endtask

   task automatic test_busy_start();
      bit to; logic [15:0] a; int p, sd, rd;
      a = 16'($urandom); p = $urandom_range(0, NP - 1);
      clear_mon(); rmode = 2; build_exp(a, 4);
      pulse_start(a, 16'd4, 4'(p));
      repeat (3) @(posedge clock);
      pulse_start(16'h0000, 16'd0, 4'd9);
      repeat (2) @(posedge clock);
      pulse_start(a + 16'h0100, 16'd2, 4'((p + 1) % NP));
      wait_done(400, to);
      repeat (6) @(posedge clock);
      sd = stream_diff(); rd = rd_diff(a, 4, p);
      checks++; if (to !== 1'b0 || sd !== -1) begin errors++; $display("FAIL busy_start_stream got to=%0d diff=%0d want 0/-1", to, sd); end
      checks++; if (err_cnt !== 0 || rd !== -1 || done_cnt !== 1) begin
         errors++; $display("FAIL busy_start_ignored got err=%0d rd=%0d done=%0d want 0/-1/1", err_cnt, rd, done_cnt); end
   endtask

   task automatic test_rate();
      bit to;
      run(16'($urandom), 3, 0, 0, to);
      for (int i = 1; i < 3; i++) begin
         checks++; if (rdc_q.size() != 3 || rdc_q[i] - rdc_q[i-1] !== LAT + 5) begin
            errors++; $display("FAIL word_period%0d got %0d want %0d", i, (rdc_q.size() > i) ? rdc_q[i] - rdc_q[i-1] : -1, LAT + 5); end
      end
   endtask

   task automatic test_random();
      bit to; logic [15:0] a; int n, p, sd, rd;
      for (int it = 0; it < 8; it++) begin
         a = (it % 3 == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
         n = $urandom_range(1, 6); p = $urandom_range(0, NP - 1);
         run(a, n, p, 2, to);
         sd = stream_diff(); rd = rd_diff(a, n, p);
         checks++; if (to !== 1'b0 || sd !== -1) begin errors++; $display("FAIL rand%0d_stream got to=%0d diff=%0d want 0/-1", it, to, sd); end
         checks++; if (rd !== -1 || proto_viol !== 0) begin errors++; $display("FAIL rand%0d_reads got rd=%0d viol=%0d want -1/0", it, rd, proto_viol); end
      end
   endtask

   task automatic test_reset_mid();
      bit to; logic vbefore; int sd;
      clear_mon(); rmode = 0;
      pulse_start(16'h4000, 16'd4, 4'd1);
      for (int i = 0; i < 200 && byte_q.size() < HDR + 6; i++) begin @(posedge clock); #1; end
      vbefore = udp1_sink_valid;
      reset_n = 1'b0; #1;
      checks++; if (vbefore !== 1'b1 || {udp1_sink_valid, busy, ctrl_rd_en, udp1_sink_last, udp1_sink_data} !== '0) begin
         errors++; $display("FAIL reset_mid got pre_valid=%b outs=%h want 1/0", vbefore, {udp1_sink_valid, busy, ctrl_rd_en, udp1_sink_last, udp1_sink_data}); end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      run(16'h0123, 1, 7, 0, to);
      sd = stream_diff();
      checks++; if (to !== 1'b0 || sd !== -1 || done_cnt !== 1) begin
         errors++; $display("FAIL after_reset_run got to=%0d diff=%0d done=%0d want 0/-1/1", to, sd, done_cnt); end
   endtask

   task automatic test_long();
      bit to; int sd;
      run(16'hFF80, 16'h0102, 8, 0, to);
      sd = stream_diff();
      checks++; if (to !== 1'b0 || sd !== -1 || byte_q.size() != 4 * 258 + HDR) begin
         errors++; $display("FAIL long_stream got to=%0d diff=%0d bytes=%0d want 0/-1/%0d", to, sd, byte_q.size(), 4 * 258 + HDR); end
`ifdef UDP_READER_HEADER_EN
      checks++; if (byte_q.size() < 2 || byte_q[0] !== 9'h001 || byte_q[1] !== 9'h002) begin
         errors++; $display("FAIL long_header got %h %h want 001 002", (byte_q.size() > 0) ? byte_q[0] : 9'h1FF, (byte_q.size() > 1) ? byte_q[1] : 9'h1FF); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      test_reset();
      test_single();
      test_backpressure();
      test_wrap();
      test_reject();
      test_busy_start();
      test_rate();
      test_random();
      test_reset_mid();
      test_long();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
